// File: rtl/tone_pkg.sv
// Shared types and constants for the tone divisor sequencer: FSM states,
// the 50 MHz C4..C5 divisor table and a helper to derive divisors from Hz.
package tone_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } tone_state_e;

    localparam int          NOTE_COUNT = 8;
    localparam logic [31:0] SILENT_DIV = 32'hFFFF_FFFF;

    // Divisors for C4 D4 E4 F4 G4 A4 B4 C5 at a 50 MHz system clock.
    localparam logic [31:0] DIV_TABLE [NOTE_COUNT] = '{
        32'd95556, 32'd85131, 32'd75843, 32'd71586,
        32'd63776, 32'd56818, 32'd50619, 32'd47778
    };

    // div = clk_hz / (2 * tone_hz); never returns zero.
    function automatic logic [31:0] hz_to_div(input logic [31:0] clk_hz,
                                              input logic [31:0] tone_hz);
        logic [32:0] twice;
        logic [31:0] q;
        twice = {tone_hz, 1'b0};
        if (tone_hz == '0) begin
            return SILENT_DIV;
        end
        q = 32'({1'b0, clk_hz} / twice);
        return (q == '0) ? 32'd1 : q;
    endfunction

endpackage

// File: rtl/tone_divisor_sequencer_dwell_timer.sv
// Free-running 32-bit cycle counter with a synchronous clear; done is high
// while the count equals the terminal value (last cycle of the window).
module dwell_timer (
    input  logic        inclk,
    input  logic        Reset,
    input  logic        clear,
    input  logic [31:0] terminal,
    output logic        done
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = clear ? 32'd0 : cnt_q + 32'd1;
    end

    always_ff @(posedge inclk) begin
        if (Reset) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The owner clears the counter on the cycle done fires, so done is a pulse.
    assign done = (cnt_q == terminal);

endmodule

// File: rtl/tone_divisor_sequencer.sv
// Steps a divider through an 8-note table, holding each note for a dwell
// window with an optional silent gap; all outputs are registered.
module tone_divisor_sequencer
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned DWELL_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES   = 2_500_000
) (
    input  logic        inclk,
    input  logic        Reset,
    input  logic        start,
    input  logic        stop,
    input  logic        dir_down,
    input  logic        loop_en,
    output logic [31:0] div_clk_count,
    output logic [2:0]  note_idx,
    output logic        note_strobe,
    output logic        busy
);

    localparam logic [31:0] PLAY_TERM = 32'(DWELL_CYCLES - 1);
    localparam logic [31:0] GAP_TERM  = (GAP_CYCLES != 0) ? 32'(GAP_CYCLES - 1) : 32'd0;
    localparam bit          HAS_GAP   = (GAP_CYCLES != 0);
    // Floor at the top of the audible band so no table entry can reach zero.
    localparam logic [31:0] MIN_DIV   = hz_to_div(32'(CLK_HZ), 32'd20_000);

    function automatic logic [31:0] note_div(input logic [2:0] idx);
        return (DIV_TABLE[idx] < MIN_DIV) ? MIN_DIV : DIV_TABLE[idx];
    endfunction

    tone_state_e state_q, state_d;
    logic [2:0]  note_q, note_d;
    logic        dir_q, dir_d;
    logic [31:0] div_q, div_d;
    logic        strobe_q, strobe_d;
    logic        busy_q, busy_d;

    logic        timer_clear;
    logic [31:0] timer_term;
    logic        timer_done;
    logic        advance;
    logic        last_note;
    logic        seq_end;
    logic [2:0]  step_note;

    dwell_timer u_dwell_timer (
        .inclk    (inclk),
        .Reset    (Reset),
        .clear    (timer_clear),
        .terminal (timer_term),
        .done     (timer_done)
    );

    always_comb begin
        state_d   = state_q;
        note_d    = note_q;
        dir_d     = dir_q;
        strobe_d  = 1'b0;
        advance   = 1'b0;
        last_note = dir_q ? (note_q == 3'd0) : (note_q == 3'd7);
        seq_end   = last_note && !loop_en;
        step_note = dir_q ? (note_q - 3'd1) : (note_q + 3'd1);

        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d  = ST_PLAY;
                    note_d   = dir_down ? 3'd7 : 3'd0;
                    dir_d    = dir_down;
                    strobe_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (timer_done) begin
                    // No trailing gap once the sequence is about to finish.
                    if (HAS_GAP && !seq_end) begin
                        state_d = ST_GAP;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (timer_done) begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (advance) begin
            if (seq_end) begin
                state_d = ST_IDLE;
            end else begin
                state_d  = ST_PLAY;
                note_d   = step_note;
                strobe_d = 1'b1;
            end
        end

        div_d  = (state_d == ST_PLAY) ? note_div(note_d) : SILENT_DIV;
        busy_d = (state_d != ST_IDLE);
    end

    // Every exit from PLAY/GAP is via done or stop, so this clears on each state entry.
    assign timer_clear = (state_q == ST_IDLE) || timer_done || stop;
    assign timer_term  = (state_q == ST_GAP) ? GAP_TERM : PLAY_TERM;

    always_ff @(posedge inclk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            note_q   <= 3'd0;
            dir_q    <= 1'b0;
            div_q    <= SILENT_DIV;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            note_q   <= note_d;
            dir_q    <= dir_d;
            div_q    <= div_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
        end
    end

    assign div_clk_count = div_q;
    assign note_idx      = note_q;
    assign note_strobe   = strobe_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_tone_divisor_sequencer.sv
// Scoreboard bench: stimulus queues the expected note on each start/advance,
// a negedge monitor pops and compares whenever note_strobe is presented.
module tb_tone_divisor_sequencer;

    localparam logic [31:0] SIL = 32'hFFFF_FFFF;
    localparam logic [31:0] TBL [8] = '{
        32'd95556, 32'd85131, 32'd75843, 32'd71586,
        32'd63776, 32'd56818, 32'd50619, 32'd47778
    };

    typedef struct {
        logic [31:0] div;
        logic [2:0]  idx;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start_a, stop_a, dir_a, loop_a;
    logic [31:0] div_a;
    logic [2:0]  idx_a;
    logic        strb_a, busy_a;
    logic        start_b, stop_b, dir_b, loop_b;
    logic [31:0] div_b;
    logic [2:0]  idx_b;
    logic        strb_b, busy_b;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   n_checks;
    int   n_errors;
    int   strobes_a;
    int   strobes_b;

    tone_divisor_sequencer #(
        .CLK_HZ(50_000_000), .DWELL_CYCLES(4), .GAP_CYCLES(2)
    ) dut_a (
        .inclk(clk), .Reset(rst), .start(start_a), .stop(stop_a),
        .dir_down(dir_a), .loop_en(loop_a), .div_clk_count(div_a),
        .note_idx(idx_a), .note_strobe(strb_a), .busy(busy_a)
    );

    tone_divisor_sequencer #(
        .CLK_HZ(50_000_000), .DWELL_CYCLES(4), .GAP_CYCLES(0)
    ) dut_b (
        .inclk(clk), .Reset(rst), .start(start_b), .stop(stop_b),
        .dir_down(dir_b), .loop_en(loop_b), .div_clk_count(div_b),
        .note_idx(idx_b), .note_strobe(strb_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (strb_a === 1'b1) begin
            strobes_a++;
            if (qa.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL mon_a unexpected strobe at %0t: idx %0d div %0d, expected no strobe",
                         $time, idx_a, div_a);
            end else begin
                ea = qa.pop_front();
                check32("mon_a div", div_a, ea.div);
                check32("mon_a idx", {29'd0, idx_a}, {29'd0, ea.idx});
            end
        end
        if (strb_b === 1'b1) begin
            strobes_b++;
            if (qb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL mon_b unexpected strobe at %0t: idx %0d div %0d, expected no strobe",
                         $time, idx_b, div_b);
            end else begin
                eb = qb.pop_front();
                check32("mon_b div", div_b, eb.div);
                check32("mon_b idx", {29'd0, idx_b}, {29'd0, eb.idx});
            end
        end
    end

    // Full up-sequence trace on dut_a; sp1/sp2 are cycles with a stray start pulse.
    task automatic run_up(input int sp1, input int sp2);
        int          bc;
        int          s0;
        int          note;
        int          ph;
        logic [31:0] ediv;
        logic        ebusy;
        bc = 0;
        s0 = strobes_a;
        for (int n = 0; n < 8; n++) qa.push_back('{TBL[n], 3'(n)});
        dir_a   = 1'b0;
        loop_a  = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k < 60; k++) begin
            note = k / 6;
            ph   = k % 6;
            if (note < 8 && ph < 4) begin
                ediv  = TBL[note];
                ebusy = 1'b1;
            end else if (note < 7) begin
                ediv  = SIL;
                ebusy = 1'b1;
            end else begin
                ediv  = SIL;
                ebusy = 1'b0;
            end
            check32("up_trace div", div_a, ediv);
            check32("up_trace busy", {31'd0, busy_a}, {31'd0, ebusy});
            if (busy_a) bc++;
            start_a = (k == sp1 || k == sp2);
            @(negedge clk);
        end
        start_a = 1'b0;
        check32("up busy cycles", 32'(bc), 32'd46);
        check32("up strobes", 32'(strobes_a - s0), 32'd8);
        check32("up final idx", {29'd0, idx_a}, 32'd7);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        strobes_a = 0;
        strobes_b = 0;
        rst = 1'b1;
        start_a = 0; stop_a = 0; dir_a = 0; loop_a = 0;
        start_b = 0; stop_b = 0; dir_b = 0; loop_b = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and idle
        for (int k = 0; k < 10; k++) begin
            check32("idle div", div_a, SIL);
            check32("idle busy", {31'd0, busy_a}, 32'd0);
            check32("idle idx", {29'd0, idx_a}, 32'd0);
            check32("idle strobe", {31'd0, strb_a}, 32'd0);
            @(negedge clk);
        end
        check32("idle b div", div_b, SIL);

        // Ascending, no loop
        run_up(-1, -1);
        repeat (3) @(negedge clk);

        // Stray starts during GAP (cycle 4) and PLAY of note 1 (cycle 7)
        run_up(4, 7);
        repeat (3) @(negedge clk);

        // Stop in 3rd cycle of note 2
        for (int n = 0; n < 3; n++) qa.push_back('{TBL[n], 3'(n)});
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (14) @(negedge clk);
        check32("pre-stop div", div_a, TBL[2]);
        check32("pre-stop idx", {29'd0, idx_a}, 32'd2);
        stop_a = 1'b1;
        @(negedge clk);
        stop_a = 1'b0;
        check32("stop busy", {31'd0, busy_a}, 32'd0);
        check32("stop div", div_a, SIL);
        check32("stop idx", {29'd0, idx_a}, 32'd2);

        // Simultaneous start+stop in IDLE
        begin
            int s0;
            s0 = strobes_a;
            start_a = 1'b1;
            stop_a  = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
            stop_a  = 1'b0;
            for (int k = 0; k < 5; k++) begin
                check32("start+stop busy", {31'd0, busy_a}, 32'd0);
                check32("start+stop div", div_a, SIL);
                @(negedge clk);
            end
            check32("start+stop strobes", 32'(strobes_a - s0), 32'd0);
        end

        // Reset in the gap after note 1, then a clean replay from C4
        for (int n = 0; n < 2; n++) qa.push_back('{TBL[n], 3'(n)});
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (10) @(negedge clk);
        check32("mid-gap div", div_a, SIL);
        check32("mid-gap busy", {31'd0, busy_a}, 32'd1);
        check32("mid-gap idx", {29'd0, idx_a}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check32("reset div", div_a, SIL);
        check32("reset busy", {31'd0, busy_a}, 32'd0);
        check32("reset idx", {29'd0, idx_a}, 32'd0);
        check32("reset strobe", {31'd0, strb_a}, 32'd0);
        @(negedge clk);
        run_up(-1, -1);

        // Descending with loop and no gap: 20 back-to-back notes
        begin
            int s0;
            s0 = strobes_b;
            for (int n = 0; n < 20; n++) qb.push_back('{TBL[7 - (n % 8)], 3'(7 - (n % 8))});
            dir_b   = 1'b1;
            loop_b  = 1'b1;
            start_b = 1'b1;
            @(negedge clk);
            start_b = 1'b0;
            dir_b   = 1'b0;
            for (int k = 0; k < 80; k++) begin
                check32("loop div", div_b, TBL[7 - ((k / 4) % 8)]);
                check32("loop busy", {31'd0, busy_b}, 32'd1);
                stop_b = (k == 79);
                @(negedge clk);
            end
            stop_b = 1'b0;
            check32("loop stop busy", {31'd0, busy_b}, 32'd0);
            check32("loop stop div", div_b, SIL);
            check32("loop stop idx", {29'd0, idx_b}, 32'd4);
            check32("loop strobes", 32'(strobes_b - s0), 32'd20);
        end

        repeat (3) @(negedge clk);
        check32("queue a drained", 32'(qa.size()), 32'd0);
        check32("queue b drained", 32'(qb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
